// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared FSM state type and default sizing for the data bus arbiter
package data_bus_pkg;
  localparam int DATA_BUS_N_REQ_DEF = 4;
  localparam int DATA_BUS_MAX_BEATS_DEF = 16;
  typedef enum logic [1:0] {IDLE, OWN, GAP} bus_state_t;
endpackage

// File: rtl/data_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts at ptr and wraps
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] j;
  assign any = |req;
  // Walk the ring backwards so the candidate closest to ptr is assigned last and wins
  always_comb begin
    onehot = '0;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) begin
        onehot = '0;
        onehot[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin shared-bus arbiter with one-cycle turnaround gap.
// Define DATA_BUS_ARB_TIMEOUT_EN to cut tenures at MAX_BEATS beats and pulse timeout.
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int N_REQ = DATA_BUS_N_REQ_DEF,
  parameter int MAX_BEATS = DATA_BUS_MAX_BEATS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  input  logic                     bus_valid,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout
);
  localparam int W = $clog2(N_REQ);
  localparam logic [W-1:0] TOP = W'(N_REQ - 1);
  bus_state_t state, state_nx;
  logic [N_REQ-1:0] grant_nx, pick_oh;
  logic [W-1:0] id_nx, last_owner, last_owner_nx, pick_idx, ptr;
  logic pick_any, done, cut;
  assign ptr = last_owner == TOP ? '0 : last_owner + 1'b1;
  assign done = (bus_valid & last[grant_id]) | ~req[grant_id];
  assign busy = state != IDLE;
  rr_pick #(.N(N_REQ), .W(W)) u_pick (
    .req(req),
    .ptr(ptr),
    .onehot(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
`ifdef DATA_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_BEATS + 1);
  logic [CW-1:0] beat_cnt;
  // Cut fires on the MAX_BEATS-th valid beat so the counter never has to wrap
  assign cut = state == OWN && bus_valid && beat_cnt == CW'(MAX_BEATS - 1);
  always_ff @(posedge clk) begin
    if (rst || state != OWN) beat_cnt <= '0;
    else if (bus_valid && beat_cnt != CW'(MAX_BEATS)) beat_cnt <= beat_cnt + 1'b1;
    timeout <= !rst && cut && !done;
  end
`else
  assign cut = 1'b0 & (MAX_BEATS > 0);
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      last_owner <= TOP;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      grant_id <= id_nx;
      last_owner <= last_owner_nx;
    end
  end
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    id_nx = grant_id;
    last_owner_nx = last_owner;
    if (state == IDLE && pick_any) begin
      state_nx = OWN;
      grant_nx = pick_oh;
      id_nx = pick_idx;
      last_owner_nx = pick_idx;
    end else if (state == OWN && (done || cut)) begin
      state_nx = GAP;
      grant_nx = '0;
      id_nx = '0;
    end else if (state == GAP) begin
      state_nx = IDLE;
    end
  end
endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the bus (2..8).
REQ-002 Parameter MAX_BEATS, default 16, maximum beats per tenure when the timeout feature is compiled in.
REQ-003 Port clk, input, 1, single clock; all logic on rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port req, input, N_REQ, bit i high = requester i wants the bus.
REQ-006 Port last, input, N_REQ, bit i high = requester i is driving its final beat this cycle.
REQ-007 Port bus_valid, input, 1, shared-bus valid as seen on the wire (1 only when a device drives).
REQ-008 Port grant, output, N_REQ, one-hot or zero bus grant, registered.
REQ-009 Port grant_id, output, clog2(N_REQ), index of current owner; 0 when no grant.
REQ-010 Port busy, output, 1, high while any grant is held or a turnaround cycle is in progress.
REQ-011 Port timeout, output, 1, one-cycle pulse when a tenure is cut at MAX_BEATS; tied 0 when the feature is out.

Function
REQ-012 FSM states: IDLE, OWN, GAP; encoding is free.
REQ-013 IDLE: if any req bit is high, select the winner by round-robin, set grant/grant_id next cycle, go to OWN; else stay in IDLE with grant=0.
REQ-014 Grant latency: req sampled high in cycle t gives grant high in cycle t+1; no combinational req-to-grant path.
REQ-015 Round-robin: search starts at (last_owner+1) mod N_REQ, wrapping; last_owner resets to N_REQ-1, so requester 0 wins first.
REQ-016 OWN: the grant is held constant; beat counter increments on each cycle with bus_valid=1.
REQ-017 OWN exit to GAP: on bus_valid & last[owner], or on req[owner]=0, evaluated at the clock edge; grant drops on the following cycle.
REQ-018 GAP lasts exactly one cycle with grant=0 (tri-state turnaround); then return to IDLE and arbitrate in the same cycle.
REQ-019 Net handover cost: minimum two cycles with no grant between consecutive tenures.
REQ-020 Simultaneous requests: exactly one winner per round-robin rule; losers keep req high and are served in rotating order.
REQ-021 A request that drops during GAP or before being granted is not served; no request memory.
REQ-022 last or bus_valid from non-owners is ignored.
REQ-023 grant shall never have more than one bit set; the bench asserts this on every cycle.
REQ-024 Beat counter width is clog2(MAX_BEATS+1); it clears on entry to OWN and never wraps.

Reset
REQ-025 When rst is high at a clock edge: state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, beat counter=0, last_owner=N_REQ-1.
REQ-026 Reset asserted mid-tenure removes grant on the next cycle, with no GAP cycle.

Configuration
REQ-027 Macro DATA_BUS_ARB_TIMEOUT_EN enables the timeout feature.
REQ-028 With the macro defined, in OWN, when the beat counter reaches MAX_BEATS, the block forces GAP and pulses timeout for one cycle; the owner moves to the back of the rotation.
REQ-029 Without the macro, tenure is unbounded, timeout is constant 0, and the counter logic is not synthesized.

Structure
REQ-030 Shared package data_bus_pkg holds the FSM state typedef and the constants DATA_BUS_N_REQ_DEF=4 and DATA_BUS_MAX_BEATS_DEF=16.
REQ-031 Sub-module rr_pick (combinational round-robin priority picker: req, pointer -> one-hot, index, any) is instantiated once.

Verification
REQ-032 Reset, then req=4'b0001 at cycle 0 -> grant=4'b0001, grant_id=0 at cycle 1; busy=1.
REQ-033 req=4'b1111 held, each owner asserts last on its 3rd beat -> grant order 0,1,2,3,0; each tenure separated by one GAP plus one IDLE cycle with grant=0.
REQ-034 Owner 2 drops req mid-tenure after 2 beats -> grant=0 on the next cycle; req=4'b1000 pending -> grant=4'b1000 two cycles later.
REQ-035 DATA_BUS_ARB_TIMEOUT_EN defined, MAX_BEATS=16, owner 1 streams without last -> after the 16th valid beat, timeout pulses once, grant drops, and the next pending requester is granted; without the macro, owner 1 keeps the grant indefinitely.
REQ-036 rst asserted while grant=4'b0100 -> grant=0 next cycle; after release, req=4'b0110 -> requester 1 is granted first.
REQ-037 Random req/last/bus_valid stimulus for 10k cycles -> grant is always one-hot or zero, and no requester with continuous req waits more than N_REQ tenures.
